// File: rtl/bram_transpose_loader.sv
// bram_transpose_loader
//
// Loads a SIZE x SIZE grid of BRAM tiles with bit-transposed row data.
// For each tile, 16 row words are collected from a valid/ready stream.
// The loader then writes one 16-bit BRAM word per bit index: bit k of the
// written word is bit <addr> of row k.
// Tiles are visited row-major: (0,0), (0,1), ... (SIZE-1,SIZE-1).
//
// Optional feature (macro LOADER_READBACK_EN): after each tile is written,
// the tile is read back through douta (1-cycle read latency). Any mismatch
// sets a sticky err flag, which is cleared by the next start.
//
// Ports:
//   clk, reset              clock (rising edge), synchronous active-low reset
//   start                   one-cycle load request (ignored while busy)
//   num_bits[7:0]           bit slices per tile; 0 or > WORD_BITS means WORD_BITS
//   s_valid/s_ready/s_data  row-word stream
//   bram_i, bram_j          tile currently selected
//   external                BRAMs are owned by the loader
//   wea, addra, dina        BRAM write port
//   douta                   BRAM read data (used only for readback)
//   busy, done, err         status; done pulses for one cycle at the end

module bram_transpose_loader #(
  parameter int SIZE      = 2,
  parameter int WORD_BITS = 160,
  parameter int ADDR_W    = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           num_bits,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [WORD_BITS-1:0] s_data,
  output logic [7:0]           bram_i,
  output logic [7:0]           bram_j,
  output logic                 external,
  output logic                 wea,
  output logic [ADDR_W-1:0]    addra,
  output logic [15:0]          dina,
  input  logic [15:0]          douta,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int NB_W  = $clog2(WORD_BITS + 1);
  localparam int SEL_W = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
  localparam logic [NB_W-1:0] WB_C   = NB_W'(WORD_BITS);
  localparam logic [7:0]      LAST_T = 8'(SIZE - 1);

`ifdef LOADER_READBACK_EN
  typedef enum logic [2:0] {IDLE, FILL, WRITE, CHECK, NEXT, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, FILL, WRITE, NEXT, DONE} state_t;
`endif

  state_t               state, state_nxt;
  logic [3:0]           rcnt;
  logic [NB_W-1:0]      bit_cnt;
  logic [NB_W-1:0]      nb_q;
  logic [7:0]           tile_i, tile_j;
  logic [WORD_BITS-1:0] rows [16];
  logic [SEL_W-1:0]     bit_sel;
  logic [15:0]          slice;
  logic                 last_bit;
  logic                 last_tile;

  assign bram_i    = tile_i;
  assign bram_j    = tile_j;
  assign last_bit  = (bit_cnt == nb_q - NB_W'(1));
  assign last_tile = (tile_i == LAST_T) && (tile_j == LAST_T);

  // During the final readback cycle bit_cnt equals nb_q, which can be one
  // past the last row bit; steer it to a legal index.
  always_comb begin
    bit_sel = '0;
    if (bit_cnt < WB_C) bit_sel = SEL_W'(bit_cnt);
    slice = '0;
    for (int k = 0; k < 16; k++) slice[k] = rows[k][bit_sel];
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    wea       = 1'b0;
    addra     = '0;
    dina      = '0;
    busy      = 1'b1;
    external  = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy     = 1'b0;
        external = 1'b0;
        if (start) state_nxt = FILL;
      end
      FILL: begin
        s_ready = 1'b1;
        if (s_valid && rcnt == 4'd15) state_nxt = WRITE;
      end
      WRITE: begin
        wea   = 1'b1;
        addra = ADDR_W'(bit_cnt);
        dina  = slice;
`ifdef LOADER_READBACK_EN
        if (last_bit) state_nxt = CHECK;
`else
        if (last_bit) state_nxt = NEXT;
`endif
      end
`ifdef LOADER_READBACK_EN
      CHECK: begin
        if (bit_cnt != nb_q) addra = ADDR_W'(bit_cnt);
        else                 state_nxt = NEXT;
      end
`endif
      NEXT: begin
        state_nxt = last_tile ? DONE : FILL;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef LOADER_READBACK_EN
  logic        err_q;
  logic [15:0] exp_d;
  assign err = err_q;
`else
  logic unused_douta;
  assign unused_douta = ^douta;
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      rcnt    <= '0;
      bit_cnt <= '0;
      nb_q    <= '0;
      tile_i  <= '0;
      tile_j  <= '0;
`ifdef LOADER_READBACK_EN
      err_q   <= 1'b0;
      exp_d   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rcnt   <= '0;
            tile_i <= '0;
            tile_j <= '0;
`ifdef LOADER_READBACK_EN
            err_q  <= 1'b0;
`endif
            if (num_bits == 8'd0 || 32'(num_bits) > WORD_BITS) nb_q <= WB_C;
            else                                                nb_q <= NB_W'(num_bits);
          end
        end
        FILL: begin
          if (s_valid) begin
            rcnt <= rcnt + 4'd1;
            if (rcnt == 4'd15) bit_cnt <= '0;
          end
        end
        WRITE: begin
          if (last_bit) bit_cnt <= '0;
          else          bit_cnt <= bit_cnt + NB_W'(1);
        end
`ifdef LOADER_READBACK_EN
        CHECK: begin
          // douta for address n arrives while bit_cnt == n+1; exp_d holds
          // the slice for address n at that point.
          bit_cnt <= bit_cnt + NB_W'(1);
          exp_d   <= slice;
          if (bit_cnt != '0 && douta != exp_d) err_q <= 1'b1;
        end
`endif
        NEXT: begin
          rcnt <= '0;
          if (!last_tile) begin
            if (tile_j == LAST_T) begin
              tile_j <= '0;
              tile_i <= tile_i + 8'd1;
            end else begin
              tile_j <= tile_j + 8'd1;
            end
          end
        end
        DONE: begin
          tile_i <= '0;
          tile_j <= '0;
        end
        default: ;
      endcase
    end
  end

  // Row buffer is not reset; it is fully rewritten before each tile is used.
  always_ff @(posedge clk) begin
    if (state == FILL && s_valid) rows[rcnt] <= s_data;
  end

endmodule

// File: tb/tb_bram_transpose_loader.sv
module tb_bram_transpose_loader;

  localparam int SIZE = 2;
  localparam int WB   = 160;
  localparam int AW   = 10;
`ifdef LOADER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    num_bits;
  logic          s_valid;
  logic          s_ready;
  logic [WB-1:0] s_data;
  logic [7:0]    bram_i, bram_j;
  logic          external, wea;
  logic [AW-1:0] addra;
  logic [15:0]   dina;
  logic [15:0]   douta;
  logic          busy, done, err;

  always #5 clk = ~clk;

  bram_transpose_loader #(.SIZE(SIZE), .WORD_BITS(WB), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .num_bits(num_bits),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .bram_i(bram_i), .bram_j(bram_j), .external(external),
    .wea(wea), .addra(addra), .dina(dina), .douta(douta),
    .busy(busy), .done(done), .err(err)
  );

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // BRAM behavioural model: 4 tiles, registered read.
  logic [15:0] mem [4][256];
  bit          fault_en = 1'b0;
  always @(posedge clk) begin
    if (wea) mem[{bram_i[0], bram_j[0]}][addra[7:0]] <= dina;
    if (fault_en && !wea && addra == 10'd1) douta <= 16'h0000;
    else                                    douta <= mem[{bram_i[0], bram_j[0]}][addra[7:0]];
  end

  typedef struct packed {
    logic [7:0]  i;
    logic [7:0]  j;
    logic [9:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t           exp_q[$];
  logic [WB-1:0] rows [64];
  logic [15:0]   cap [256];
  bit            cap_en   = 1'b0;
  bit            err_exp  = 1'b0;
  bit            mon_en   = 1'b0;
  bit            prev_done = 1'b0;
  int            done_cnt = 0;
  int            max_addr = 0;
  wr_t           e;

  // Expected writes: tile t in row-major order, address b carries bit b of rows 0..15.
  task automatic build_model(input int nb_eff);
    logic [15:0] d;
    exp_q.delete();
    for (int t = 0; t < SIZE * SIZE; t++)
      for (int b = 0; b < nb_eff; b++) begin
        d = '0;
        for (int k = 0; k < 16; k++) d[k] = rows[t * 16 + k][b];
        exp_q.push_back('{i: 8'(t / SIZE), j: 8'(t % SIZE), a: 10'(b), d: d});
      end
  endtask

  task automatic gen_rows(input bit pat_k);
    logic [WB-1:0] r;
    for (int n = 0; n < 64; n++) begin
      for (int w = 0; w < WB / 32; w++) r[w * 32 +: 32] = $urandom;
      if (pat_k) r[31:0] = 32'(n % 16);
      rows[n] = r;
    end
  endtask

  always @(negedge clk) begin
    if (reset && mon_en) begin
      if (wea) begin
        if (exp_q.size() == 0) begin
          tot_cnt++;
          $display("FAIL unexpected_write: got addr %0d data %0h expected no write", addra, dina);
        end else begin
          e = exp_q.pop_front();
          chk("write", {bram_i, bram_j, addra, dina}, 64'(e));
        end
        if (cap_en && bram_i == 8'd0 && bram_j == 8'd0) cap[addra[7:0]] = dina;
        if (int'(addra) > max_addr) max_addr = int'(addra);
      end else begin
        chk("dina_idle", dina, 16'h0000);
      end
      if (done) begin
        done_cnt++;
        chk("writes_before_done", exp_q.size(), 0);
        chk("err_at_done", err, err_exp);
      end
      if (prev_done) chk("ext_after_done", external, 1'b0);
      prev_done = done;
    end
  end

  task automatic run_load(input int nb_in, input bit pat_k, input bit toggle,
                          input bit mid_start, input bit fault);
    int nb_eff, cyc, idx, lat, exp_lat;
    bit seen, v;
    nb_eff = (nb_in == 0 || nb_in > WB) ? WB : nb_in;
    gen_rows(pat_k);
    build_model(nb_eff);
    if (pat_k) begin
      chk("model_a0", exp_q[0].d, 16'hAAAA);
      chk("model_a1", exp_q[1].d, 16'hCCCC);
      chk("model_a2", exp_q[2].d, 16'hF0F0);
      chk("model_a3", exp_q[3].d, 16'hFF00);
    end
    fault_en = fault;
    err_exp  = fault && RB && nb_eff >= 2;
    done_cnt = 0;
    max_addr = 0;
    cap_en   = pat_k;
    for (int a = 0; a < 256; a++) cap[a] = 16'h5A5A;
    exp_lat = 4 * (17 + nb_eff) + (RB ? 4 * (nb_eff + 1) : 0) + 1;
    cyc = 0; idx = 0; lat = 0; seen = 1'b0;
    while (!seen && cyc < 20000) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; lat = cyc; end
      start    = (cyc == 0) || (mid_start && (cyc == 5 || cyc == 40));
      num_bits = (cyc == 0) ? 8'(nb_in) : 8'($urandom);
      v        = toggle ? (cyc % 2 == 1) : 1'b1;
      if (idx < 64) begin
        s_valid = v;
        s_data  = rows[idx];
      end else begin
        s_valid = 1'($urandom);
        for (int w = 0; w < WB / 32; w++) s_data[w * 32 +: 32] = $urandom;
      end
      if (s_valid && s_ready && idx < 64) idx++;
      cyc++;
    end
    s_valid = 1'b0;
    start   = 1'b0;
    chk("done_seen", seen, 1'b1);
    if (!toggle) chk("latency", lat, exp_lat);
    repeat (3) @(negedge clk);
    chk("done_once", done_cnt, 1);
    chk("idle_busy", busy, 1'b0);
    chk("rows_used", idx, 64);
    chk("writes_left", exp_q.size(), 0);
    chk("max_addra", max_addr, nb_eff - 1);
    if (pat_k) begin
      chk("cap_a0", cap[0], 16'hAAAA);
      chk("cap_a1", cap[1], 16'hCCCC);
      chk("cap_a2", cap[2], 16'hF0F0);
      chk("cap_a3", cap[3], 16'hFF00);
      chk("cap_a4", cap[4], 16'h0000);
      chk("cap_a31", cap[31], 16'h0000);
    end
    cap_en   = 1'b0;
    fault_en = 1'b0;
  endtask

  task automatic reset_mid_write();
    int cyc, idx;
    bit found;
    gen_rows(1'b0);
    build_model(32);
    cyc = 0; idx = 0; found = 1'b0;
    while (!found && cyc < 2000) begin
      @(negedge clk);
      if (wea && addra == 10'd10) begin
        found = 1'b1;
      end else begin
        start    = (cyc == 0);
        num_bits = 8'd32;
        s_valid  = 1'b1;
        s_data   = rows[idx];
        if (s_ready && idx < 63) idx++;
      end
      cyc++;
    end
    chk("rst_found_addr10", found, 1'b1);
    reset   = 1'b0;
    start   = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    chk("rst_wea", wea, 1'b0);
    chk("rst_external", external, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_addra", addra, 10'd0);
    chk("rst_tile", {bram_i, bram_j}, 16'h0000);
    exp_q.delete();
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; num_bits = 8'd0; s_valid = 1'b0; s_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_wea", wea, 1'b0);
    chk("reset_s_ready", s_ready, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_external", external, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_err", err, 1'b0);
    chk("reset_dina", dina, 16'h0000);
    chk("reset_addra", addra, 10'd0);
    chk("reset_bram_i", bram_i, 8'd0);
    chk("reset_bram_j", bram_j, 8'd0);
    reset = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    run_load(32, 1'b1, 1'b0, 1'b0, 1'b0);
    run_load(32, 1'b1, 1'b1, 1'b0, 1'b0);
    reset_mid_write();
    run_load(32, 1'b1, 1'b0, 1'b0, 1'b0);
    run_load(0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_load(32, 1'b1, 1'b0, 1'b0, 1'b1);
    run_load(1, 1'b0, 1'b1, 1'b0, 1'b0);
    run_load(200, 1'b0, 1'b0, 1'b0, 1'b0);
    run_load(255, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int n = 0; n < 2; n++)
      run_load(int'($urandom_range(1, 160)), 1'b0, 1'($urandom), 1'b1, 1'($urandom));

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/bram_transpose_loader.md
BRAM_TRANSPOSE_LOADER -- requirements
Module: bram_transpose_loader

Interface
REQ-001 SHALL have parameter SIZE, default 2: tile grid is SIZE x SIZE BRAMs.
REQ-002 SHALL have parameter WORD_BITS, default 160: width of one row word.
REQ-003 SHALL have parameter ADDR_W, default 10: BRAM address width.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle load request.
REQ-007 SHALL have port num_bits  input  8  bit-slices written per tile; 0 means WORD_BITS.
REQ-008 SHALL have ports s_valid input 1, s_ready output 1, s_data input WORD_BITS: row-word stream.
REQ-009 SHALL have ports bram_i output 8, bram_j output 8: selected tile.
REQ-010 SHALL have port external  output  1  BRAMs owned by loader.
REQ-011 SHALL have ports wea output 1, addra output ADDR_W, dina output 16, douta input 16.
REQ-012 SHALL have ports busy output 1, done output 1, err output 1.

Function
REQ-013 SHALL use states IDLE, FILL, WRITE, CHECK (macro only), NEXT, DONE.
REQ-014 IDLE: start=1 -> FILL, tile (0,0), row count 0, err cleared; num_bits latched.
REQ-015 FILL: s_ready=1; each s_valid&&s_ready stores s_data into row[rcnt], rows strictly 0..15; after row 15 -> WRITE, bit index 0.
REQ-016 WRITE: one write per cycle: wea=1, addra=bit, dina[k]=row[k][bit] for k=0..15, bit 0 = s_data LSB; after bit num_bits-1 -> CHECK or NEXT.
REQ-017 NEXT: j increments; j wrap from SIZE-1 to 0 increments i; after tile (SIZE-1,SIZE-1) -> DONE, else -> FILL, row count 0.
REQ-018 DONE: done=1 for exactly one cycle, then IDLE.
REQ-019 external=1 and busy=1 in FILL, WRITE, CHECK, NEXT, DONE; 0 in IDLE.
REQ-020 s_ready=0 and wea=0 outside FILL and WRITE respectively; dina=0 when wea=0.
REQ-021 start while busy SHALL be ignored; s_valid outside FILL SHALL be ignored.
REQ-022 Tile latency: 16 accepted rows + num_bits write cycles + 1 NEXT cycle (+ CHECK cycles when enabled).
REQ-023 num_bits > WORD_BITS SHALL be clamped to WORD_BITS; addra SHALL not exceed num_bits-1.

Reset
REQ-024 reset=0 at any clock edge, including mid-load, SHALL force IDLE with busy, done, err, external, wea, s_ready, dina, addra, bram_i, bram_j all 0.
REQ-025 Row buffer contents need not be cleared by reset.

Configuration
REQ-026 With LOADER_READBACK_EN defined, each tile after WRITE SHALL enter CHECK: addra steps 0..num_bits-1 with wea=0, douta compared one cycle later against expected slice, any mismatch sets err sticky until next start; CHECK lasts num_bits+1 cycles.
REQ-027 Without LOADER_READBACK_EN, CHECK SHALL not exist, WRITE goes directly to NEXT, err SHALL be constant 0.

Verification
REQ-028 Reset release, start, 16 rows where row k low 32 bits = k, num_bits=32 -> tile (0,0) writes addr0 0xAAAA, addr1 0xCCCC, addr2 0xF0F0, addr3 0xFF00, addr4..31 0x0000.
REQ-029 Same stream repeated 4 times -> tiles visited in order (0,0),(0,1),(1,0),(1,1); done pulses once; external falls the cycle after done.
REQ-030 s_valid toggled every other cycle during FILL -> rows stored in order, identical dina to REQ-028.
REQ-031 reset=0 asserted during WRITE at addr 10 -> next cycle wea=0, external=0, busy=0; new start reloads tile (0,0) from row 0.
REQ-032 num_bits=0 -> 160 writes per tile, last addra=159; start pulsed while busy -> no effect.
REQ-033 With LOADER_READBACK_EN, douta forced to 0x0000 at addr1 readback -> err=1 by DONE; without macro err stays 0.
